// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end. Holds the PC, issues reads to a synchronous
// instruction memory (one-cycle read latency), and buffers the returned words
// with their addresses in a DEPTH-entry circular queue. Decode drains the
// queue through a valid/ready handshake. A redirect reloads the PC and
// flushes both the queued words and the response currently in flight.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_en      read request this cycle
//   imem_addr    read address (current PC)
//   imem_rdata   read data, valid the cycle after imem_en
//   redirect     taken branch: load redirect_pc, flush queue
//   redirect_pc  branch target
//   inst_valid   queue head valid
//   inst         queue head word (0 when empty)
//   inst_pc      queue head address (0 when empty)
//   inst_ready   decode accepts the head
//   level        number of queued entries
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_en,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         inst_valid,
  output logic [DATA_W-1:0]            inst,
  output logic [ADDR_W-1:0]            inst_pc,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    DEPTH_L = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_L  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] word_mem_r [DEPTH];
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_addr_r;
  logic              kill_r;

  logic [CNT_W:0]    used_s;
  logic              issue_s;
  logic              write_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_next_s;

  // Credit check, request issue, response write and pop qualification.
  always_comb begin
    // Queued plus in-flight words must leave room for one more response.
    used_s  = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s = rst_n & ~redirect & (used_s < DEPTH_L);
    // A response landing in a redirect cycle belongs to the old path.
    write_s = inflight_r & ~kill_r & ~redirect;
    pop_s   = (count_r != {CNT_W{1'b0}}) & inst_ready;
  end

  // Next occupancy: a write and a pop in the same cycle cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({write_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Memory-side and decode-side outputs; head fields read as zero when empty.
  always_comb begin
    imem_en    = issue_s;
    imem_addr  = pc_r;
    level      = count_r;
    inst_valid = (count_r != {CNT_W{1'b0}});
    if (inst_valid) begin
      inst    = word_mem_r[rd_ptr_r];
      inst_pc = addr_mem_r[rd_ptr_r];
    end else begin
      inst    = {DATA_W{1'b0}};
      inst_pc = {ADDR_W{1'b0}};
    end
  end

  // PC: redirect target wins, otherwise advance on every issued request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect) begin
      pc_r <= redirect_pc;
    end else if (issue_s) begin
      pc_r <= pc_r + STEP_L;
    end else begin
      pc_r <= pc_r;
    end
  end

  // In-flight tracking: remembers the address of last cycle's request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r      <= 1'b0;
      inflight_addr_r <= {ADDR_W{1'b0}};
      kill_r          <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_addr_r <= issue_s ? pc_r : inflight_addr_r;
      // With one-cycle latency an older response always lands inside the
      // redirect cycle itself, so this only guards a request racing a flush.
      kill_r          <= redirect & issue_s;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_r <= pop_s   ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      wr_ptr_r <= write_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      count_r  <= count_next_s;
    end
  end

  // Queue storage: word and its fetch address, written at wr_ptr.
  always_ff @(posedge clk) begin
    if (write_s) begin
      word_mem_r[wr_ptr_r] <= imem_rdata;
      addr_mem_r[wr_ptr_r] <= inflight_addr_r;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  level;

  logic        rst8_n;
  logic        imem_en8;
  logic [7:0]  imem_addr8;
  logic [7:0]  imem_rdata8;
  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic        inst_valid8;
  logic [7:0]  inst8;
  logic [7:0]  inst_pc8;
  logic        inst_ready8;
  logic [2:0]  level8;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [31:0] last_pop_pc = 32'd0;
  logic [31:0] exp_q [$];
  logic [7:0]  exp8_pc = 8'hFC;

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .level(level)
  );

  fetch_queue #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .PC_STEP(4), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .rst_n(rst8_n), .imem_en(imem_en8), .imem_addr(imem_addr8),
    .imem_rdata(imem_rdata8), .redirect(redirect8), .redirect_pc(redirect_pc8),
    .inst_valid(inst_valid8), .inst(inst8), .inst_pc(inst_pc8),
    .inst_ready(inst_ready8), .level(level8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word32(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1F2E3D4C;
  endfunction

  function automatic logic [7:0] word8(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hA5;
  endfunction

  // Synchronous instruction memories: data one cycle after the address.
  always @(posedge clk) begin
    imem_rdata  <= word32(imem_addr);
    imem_rdata8 <= word8(imem_addr8);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference stream: after reset or a redirect, words come from start, start+4, ...
  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i) * 32'd4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 32-bit instance: every handshake is checked against the stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (inst_valid) begin
          chk("valid_level", 64'(level != 3'd0), 64'd1);
          if (inst_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_empty: got pop of %0h expected none", inst_pc);
            end else begin
              chk("pop_pc", 64'(inst_pc), 64'(exp_q[0]));
              chk("pop_word", 64'(inst), 64'(word32(exp_q[0])));
              void'(exp_q.pop_front());
            end
            last_pop_pc = inst_pc;
            pops++;
          end
        end else begin
          chk("idle_inst", 64'(inst), 64'd0);
          chk("idle_pc", 64'(inst_pc), 64'd0);
          chk("idle_level", 64'(level), 64'd0);
        end
        chk("level_bound", 64'(level <= 3'd4), 64'd1);
      end
      if (!rst_n) fill(32'd0);
      else if (redirect) fill(redirect_pc);
    end
  end

  // Scoreboard for the 8-bit wrap instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst8_n) begin
        exp8_pc = 8'hFC;
      end else if (inst_valid8 && inst_ready8) begin
        chk("w8_pc", 64'(inst_pc8), 64'(exp8_pc));
        chk("w8_word", 64'(inst8), 64'(word8(exp8_pc)));
        exp8_pc = exp8_pc + 8'd4;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = rdy;
    #1;
    chk("rst_en", 64'(imem_en), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int seg;
    rst8_n       = 1'b0;
    redirect8    = 1'b0;
    redirect_pc8 = 8'd0;
    inst_ready8  = 1'b0;

    // Backpressure fill from reset: four requests then stall.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("fill_en", 64'(imem_en), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) chk("fill_addr", 64'(imem_addr), 64'(4 * i));
      step();
      #1;
    end
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_head_pc", 64'(inst_pc), 64'd0);
    chk("fill_head_word", 64'(inst), 64'(word32(32'd0)));

    // Streaming from reset: valid from cycle 2, no bubbles after.
    do_reset(1'b1);
    for (int i = 0; i < 22; i++) begin
      chk("stream_valid", 64'(inst_valid), (i >= 2) ? 64'd1 : 64'd0);
      step();
      #1;
    end

    // Redirect with 2 queued and 1 in flight.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
    end
    chk("rd_level_before", 64'(level), 64'd2);
    chk("rd_en_before", 64'(imem_en), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("rd_en_blocked", 64'(imem_en), 64'd0);
    step();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("rd_req_en", 64'(imem_en), 64'd1);
    chk("rd_req_addr", 64'(imem_addr), 64'h100);
    chk("rd_t1_valid", 64'(inst_valid), 64'd0);
    step();
    #1;
    chk("rd_t2_valid", 64'(inst_valid), 64'd0);
    step();
    #1;
    chk("rd_t3_valid", 64'(inst_valid), 64'd1);
    chk("rd_t3_pc", 64'(inst_pc), 64'h100);
    step();
    #1;
    chk("rd_t4_pc", 64'(inst_pc), 64'h104);

    // Redirect coinciding with the pop of head 0x10.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("rp_level", 64'(level), 64'd2);
    chk("rp_head", 64'(inst_pc), 64'h10);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    inst_ready = 1'b0;
    redirect   = 1'b0;
    #1;
    chk("rp_level_after", 64'(level), 64'd0);
    chk("rp_valid_after", 64'(inst_valid), 64'd0);
    chk("rp_consumed", 64'(last_pop_pc), 64'h10);
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset while the queue holds words and a response is in flight.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("ar_level_before", 64'(level), 64'd3);
    do_reset(1'b0);
    chk("ar_first_en", 64'(imem_en), 64'd1);
    chk("ar_first_addr", 64'(imem_addr), 64'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic: random backpressure and redirects.
    seg = 0;
    pops = 0;
    for (int c = 0; c < 1500; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if (seg >= 60 || $urandom_range(0, 11) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        seg = 0;
      end else begin
        redirect = 1'b0;
        seg++;
      end
      step();
    end
    redirect   = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rand_progress", 64'(pops > 300), 64'd1);

    // Address wrap on the 8-bit instance.
    inst_ready8 = 1'b1;
    rst8_n      = 1'b1;
    #1;
    chk("w8_a0", 64'({imem_en8, imem_addr8}), 64'h1FC);
    step();
    #1;
    chk("w8_a1", 64'({imem_en8, imem_addr8}), 64'h100);
    step();
    #1;
    chk("w8_a2", 64'({imem_en8, imem_addr8}), 64'h104);
    chk("w8_head0", 64'({inst_valid8, inst_pc8}), 64'h1FC);
    step();
    #1;
    chk("w8_head1", 64'({inst_valid8, inst_pc8}), 64'h100);
    step();
    #1;
    chk("w8_head2", 64'({inst_valid8, inst_pc8}), 64'h104);
    for (int i = 0; i < 6; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
